// File: rtl/ascii_pkg.sv
// Shared constants, state encoding and character classifiers for the
// ASCII-decimal to binary converter.
package ascii_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHAR = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACUM = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// acc*10 + d using shifts, evaluated 4 bits wider than acc so the limit
// check against MAX_VAL can never be fooled by wrap-around.
module mul10_add
  import ascii_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int MAX_VAL = 4095
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] acc_next,
  output logic             over
);

  localparam logic [WIDTH+3:0] MAX_EXT = (WIDTH+4)'(MAX_VAL);

  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] sum_ext;

  assign acc_ext  = {4'b0000, acc};
  assign sum_ext  = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, d};
  // Truncation is only consumed when over is low, so no information is lost.
  assign acc_next = sum_ext[WIDTH-1:0];
  assign over     = (sum_ext > MAX_EXT);

endmodule

// File: rtl/ascii_a_bin.sv
// Streams ASCII decimal digits (MSD first, CR/LF terminated) into an
// unsigned WIDTH-bit value with bad-character and overflow reporting.
module ascii_a_bin
  import ascii_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int MAX_VAL = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dig_valid,
  input  logic [7:0]       dig_data,
  output logic             dig_ready,
  output logic [WIDTH-1:0] numero,
  output logic             num_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             ovf_reg;
  logic [3:0]       d_reg;
  logic [WIDTH-1:0] numero_reg;
  logic             num_valid_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;

  logic [WIDTH-1:0] acc_next;
  logic             over_next;

  mul10_add #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_mul10_add (
    .acc      (acc_reg),
    .d        (d_reg),
    .acc_next (acc_next),
    .over     (over_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      d_reg         <= '0;
      numero_reg    <= '0;
      num_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      num_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ACUM: begin
          if (dig_valid) begin
            if (is_digit(dig_data)) begin
              // The low nibble of '0'..'9' is the digit value itself.
              d_reg     <= dig_data[3:0];
              state_reg <= ST_CALC;
            end else if (is_term(dig_data)) begin
              // A terminator with no digits before it (e.g. LF of CRLF) is dropped.
              if (state_reg == ST_ACUM) begin
                state_reg <= ST_OUT;
                if (ovf_reg) begin
                  err_reg      <= 1'b1;
                  err_code_reg <= ERR_OVF;
                end else begin
                  numero_reg    <= acc_reg;
                  num_valid_reg <= 1'b1;
                end
              end
            end else begin
              state_reg    <= ST_OUT;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_CHAR;
            end
          end
        end
        ST_CALC: begin
          // Once overflowed, the accumulator is frozen rather than wrapped.
          if (!ovf_reg && !over_next) begin
            acc_reg <= acc_next;
          end else begin
            ovf_reg <= 1'b1;
          end
          state_reg <= ST_ACUM;
        end
        ST_OUT: begin
          acc_reg   <= '0;
          ovf_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dig_ready = (state_reg == ST_IDLE) || (state_reg == ST_ACUM);
  assign numero    = numero_reg;
  assign num_valid = num_valid_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_ascii_a_bin.sv
// Randomized and directed stimulus for ascii_a_bin, checked per character
// against a value-level model of the decimal parsing rules.
module tb_ascii_a_bin;

  localparam int WIDTH   = 12;
  localparam int MAX_VAL = 4095;

  logic             clk;
  logic             rst_n;
  logic             dig_valid;
  logic [7:0]       dig_data;
  logic             dig_ready;
  logic [WIDTH-1:0] numero;
  logic             num_valid;
  logic             err;
  logic [1:0]       err_code;

  ascii_a_bin #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dig_valid (dig_valid),
    .dig_data  (dig_data),
    .dig_ready (dig_ready),
    .numero    (numero),
    .num_valid (num_valid),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: exact decimal value, overflow sticky once past MAX_VAL.
  int         m_val;
  bit         m_ovf;
  bit         m_have;
  int         m_num;
  int         m_code;
  int         exp_nv;
  int         exp_err;

  task automatic model_reset();
    m_val = 0; m_ovf = 0; m_have = 0; m_num = 0; m_code = 0;
  endtask

  task automatic model_step(input logic [7:0] c, output bit e_nv, output bit e_err,
                            output bit e_rdy);
    int t;
    e_nv = 0; e_err = 0; e_rdy = 0;
    if (c >= 8'h30 && c <= 8'h39) begin
      m_have = 1;
      if (!m_ovf) begin
        t = m_val * 10 + int'(c - 8'h30);
        if (t > MAX_VAL) m_ovf = 1;
        else m_val = t;
      end
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (!m_have) begin
        e_rdy = 1;
      end else begin
        if (m_ovf) begin
          e_err = 1; m_code = 2;
        end else begin
          e_nv = 1; m_num = m_val;
        end
        m_val = 0; m_ovf = 0; m_have = 0;
      end
    end else begin
      e_err = 1; m_code = 1;
      m_val = 0; m_ovf = 0; m_have = 0;
    end
    exp_nv  += int'(e_nv);
    exp_err += int'(e_err);
  endtask

  int cnt_nv  = 0;
  int cnt_err = 0;
  int cnt_both = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      cnt_nv  <= cnt_nv + int'(num_valid);
      cnt_err <= cnt_err + int'(err);
      cnt_both <= cnt_both + int'(num_valid && err);
    end
  end

  bit     gap_en;
  longint xfer_t[$];

  // Called at a negedge; returns at a negedge with the DUT ready or idle.
  task automatic send_char(input logic [7:0] c);
    int waited;
    bit e_nv, e_err, e_rdy;
    dig_valid = 1'b1;
    dig_data  = c;
    waited    = 0;
    while (!dig_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!dig_ready) begin
      check_val("ready_timeout", 32'(dig_ready), 1);
      dig_valid = 1'b0;
      return;
    end
    @(posedge clk);
    xfer_t.push_back(longint'($time));
    model_step(c, e_nv, e_err, e_rdy);
    @(negedge clk);
    check_val("num_valid", 32'(num_valid), 32'(e_nv));
    check_val("err", 32'(err), 32'(e_err));
    check_val("numero", 32'(numero), 32'(m_num));
    check_val("err_code", 32'(err_code), 32'(m_code));
    check_val("ready_t1", 32'(dig_ready), 32'(e_rdy));
    if (!e_rdy) begin
      @(negedge clk);
      check_val("ready_t2", 32'(dig_ready), 1);
      check_val("nv_t2", 32'(num_valid), 0);
      check_val("err_t2", 32'(err), 0);
    end
    if (gap_en && $urandom_range(0, 3) == 0) begin
      dig_valid = 1'b0;
      dig_data  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_number(input int v, input int lz, input logic [7:0] term);
    int digs[$];
    int x;
    x = v;
    do begin
      digs.push_front(x % 10);
      x = x / 10;
    end while (x > 0);
    repeat (lz) digs.push_front(0);
    foreach (digs[i]) send_char(8'(8'h30 + digs[i]));
    send_char(term);
  endtask

  function automatic logic [7:0] bad_char();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255));
    while ((c >= 8'h30 && c <= 8'h39) || c == 8'h0D || c == 8'h0A);
    return c;
  endfunction

  function automatic logic [7:0] rand_term();
    return ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_nv = 0; exp_err = 0;
    model_reset();
    gap_en    = 0;
    dig_valid = 1'b0;
    dig_data  = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_numero", 32'(numero), 0);
    check_val("rst_nv", 32'(num_valid), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_code", 32'(err_code), 0);
    check_val("rst_ready", 32'(dig_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: first digit to terminator transfer is 8 cycles, pulse one later.
    xfer_t.delete();
    send_str("1234\r");
    check_val("latency_cycles", 32'((xfer_t[4] - xfer_t[0]) / 10), 8);
    check_val("val_1234", 32'(numero), 1234);

    send_str("4095\n");
    check_val("val_4095", 32'(numero), 4095);
    send_str("4096\r");
    check_val("ovf_keep", 32'(numero), 4095);
    check_val("ovf_code", 32'(err_code), 2);

    send_str("12a7\r");
    check_val("bad_code", 32'(err_code), 1);
    check_val("after_bad", 32'(numero), 7);

    send_str("\r\n\r");
    send_str("0\r");
    check_val("val_zero", 32'(numero), 0);
    send_str("0004095\r");
    check_val("lead_zero", 32'(numero), 4095);
    send_str("56\r");
    check_val("val_56", 32'(numero), 56);

    // Asynchronous reset in the middle of a number.
    send_str("98");
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_numero", 32'(numero), 0);
    check_val("arst_ready", 32'(dig_ready), 1);
    check_val("arst_code", 32'(err_code), 0);
    model_reset();
    dig_valid = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    send_str("\r3\r");
    check_val("after_rst", 32'(numero), 3);

    gap_en = 1;
    repeat (250) begin
      case ($urandom_range(0, 9))
        0: begin
          repeat ($urandom_range(0, 3)) send_char(8'(8'h30 + $urandom_range(0, 9)));
          send_char(bad_char());
        end
        1: repeat ($urandom_range(1, 3)) send_char(rand_term());
        2: begin
          repeat ($urandom_range(5, 8)) send_char(8'(8'h30 + $urandom_range(1, 9)));
          send_char(rand_term());
        end
        3: send_number($urandom_range(MAX_VAL - 20, MAX_VAL + 20), $urandom_range(0, 2),
                       rand_term());
        default: send_number($urandom_range(0, MAX_VAL + 300), $urandom_range(0, 3),
                             rand_term());
      endcase
    end
    dig_valid = 1'b0;
    repeat (3) @(negedge clk);

    check_val("count_nv", 32'(cnt_nv), 32'(exp_nv));
    check_val("count_err", 32'(cnt_err), 32'(exp_err));
    check_val("nv_err_overlap", 32'(cnt_both), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
